// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count monitor: sample classes, FSM states,
// output-select codes and status bit positions.
package count_mon_pkg;

    typedef enum logic [1:0] {HOLD = 2'd0, UP = 2'd1, DOWN = 2'd2, JUMP = 2'd3} class_e;
    typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_e;

    localparam logic [1:0] OUT_SEL_STEPS  = 2'b00;
    localparam logic [1:0] OUT_SEL_JUMPS  = 2'b01;
    localparam logic [1:0] OUT_SEL_PREV   = 2'b10;
    localparam logic [1:0] OUT_SEL_STATUS = 2'b11;

    localparam int STS_WRAP   = 6;
    localparam int STS_JUMP   = 5;
    localparam int STS_DIRCHG = 4;
    localparam int STS_DIR_UP = 3;
    localparam int STS_TRACK  = 2;

    function automatic class_e classify(input logic [7:0] delta);
        case (delta)
            8'h00:   return HOLD;
            8'h01:   return UP;
            8'hFF:   return DOWN;
            default: return JUMP;
        endcase
    endfunction

endpackage

// File: rtl/count_mon_sync.sv
// Synchroniser for the observed count bus. MON_GLITCH_FILTER_EN adds a stage that
// only follows the synchroniser once its last two flops agree.
module count_mon_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d_in,
    output logic [7:0] cur
);

    logic [SYNC_STAGES-1:0][7:0] stage_q, stage_d;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

`ifdef MON_GLITCH_FILTER_EN
    logic [7:0] cur_q, cur_d;

    always_comb begin
        cur_d = cur_q;
        if (stage_q[SYNC_STAGES-1] == stage_q[SYNC_STAGES-2]) cur_d = stage_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_q <= '0;
        else        cur_q <= cur_d;
    end

    assign cur = cur_q;
`else
    assign cur = stage_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/tt_um_count_monitor.sv
// Count-bus monitor: classifies successive samples of uio_in and keeps step/jump
// statistics. Optional MON_GLITCH_FILTER_EN enables the synchroniser glitch filter.
//   state | meaning
//   IDLE  | no reference sample yet; next sample only loads prev
//   TRACK | prev valid; each sample is classified against it
module tt_um_count_monitor
    import count_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int JUMP_MAX    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] cur;
    logic       sample, clear, unused_ui;
    class_e     cls;
    logic [7:0] status;

    state_e     state_q, state_d;
    class_e     last_class_q, last_class_d;
    logic [7:0] prev_q, prev_d, steps_q, steps_d, jump_cnt_q, jump_cnt_d;
    logic       wrap_q, wrap_d, jump_st_q, jump_st_d, dirchg_q, dirchg_d;
    logic       dir_up_q, dir_up_d, step_seen_q, step_seen_d;

    count_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (uio_in),
        .cur   (cur)
    );

    assign sample    = ena & ui_in[0] & ~ui_in[1];
    assign clear     = ena & ui_in[1];
    assign unused_ui = &{1'b0, ui_in[7:4]};
    assign cls       = classify(cur - prev_q);

    always_comb begin
        state_d      = state_q;
        last_class_d = last_class_q;
        prev_d       = prev_q;
        steps_d      = steps_q;
        jump_cnt_d   = jump_cnt_q;
        wrap_d       = wrap_q;
        jump_st_d    = jump_st_q;
        dirchg_d     = dirchg_q;
        dir_up_d     = dir_up_q;
        step_seen_d  = step_seen_q;
        if (clear) begin
            state_d      = IDLE;
            last_class_d = HOLD;
            prev_d       = '0;
            steps_d      = '0;
            jump_cnt_d   = '0;
            wrap_d       = 1'b0;
            jump_st_d    = 1'b0;
            dirchg_d     = 1'b0;
            dir_up_d     = 1'b0;
            step_seen_d  = 1'b0;
        end else if (sample) begin
            prev_d = cur;
            if (state_q == IDLE) begin
                state_d = TRACK;
            end else begin
                last_class_d = cls;
                case (cls)
                    UP, DOWN: begin
                        steps_d     = steps_q + 8'd1;
                        dir_up_d    = (cls == UP);
                        step_seen_d = 1'b1;
                        // Direction change needs an earlier step to compare against.
                        if (step_seen_q && (dir_up_q != (cls == UP))) dirchg_d = 1'b1;
                        if (cls == UP && prev_q == 8'hFF) wrap_d = 1'b1;
                    end
                    JUMP: begin
                        if (jump_cnt_q < 8'(JUMP_MAX)) jump_cnt_d = jump_cnt_q + 8'd1;
                        jump_st_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_class_q <= HOLD;
            prev_q       <= '0;
            steps_q      <= '0;
            jump_cnt_q   <= '0;
            wrap_q       <= 1'b0;
            jump_st_q    <= 1'b0;
            dirchg_q     <= 1'b0;
            dir_up_q     <= 1'b0;
            step_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_class_q <= last_class_d;
            prev_q       <= prev_d;
            steps_q      <= steps_d;
            jump_cnt_q   <= jump_cnt_d;
            wrap_q       <= wrap_d;
            jump_st_q    <= jump_st_d;
            dirchg_q     <= dirchg_d;
            dir_up_q     <= dir_up_d;
            step_seen_q  <= step_seen_d;
        end
    end

    always_comb begin
        status = '0;
        status[STS_WRAP]   = wrap_q;
        status[STS_JUMP]   = jump_st_q;
        status[STS_DIRCHG] = dirchg_q;
        status[STS_DIR_UP] = dir_up_q;
        status[STS_TRACK]  = (state_q == TRACK);
        status[1:0]        = last_class_q;
    end

    always_comb begin
        case (ui_in[3:2])
            OUT_SEL_STEPS: uo_out = steps_q;
            OUT_SEL_JUMPS: uo_out = jump_cnt_q;
            OUT_SEL_PREV:  uo_out = prev_q;
            default:       uo_out = status;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_count_monitor.sv
// Randomized bench for tt_um_count_monitor against a sample-level reference model.
module tb_tt_um_count_monitor;

    localparam int SYNC = 2;
    localparam int SETTLE = SYNC + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int  m_prev, m_steps, m_jumps, m_last;
    bit  m_track, m_wrap, m_jst, m_dirchg, m_dirup, m_seen;

    tt_um_count_monitor #(.SYNC_STAGES(SYNC), .JUMP_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        m_prev = 0; m_steps = 0; m_jumps = 0; m_last = 0;
        m_track = 0; m_wrap = 0; m_jst = 0; m_dirchg = 0; m_dirup = 0; m_seen = 0;
    endtask

    task automatic mdl_sample(input int v);
        int d;
        bit up;
        if (m_track) begin
            d = (v - m_prev + 256) % 256;
            if (d == 0) m_last = 0;
            else if (d == 1 || d == 255) begin
                up = (d == 1);
                m_last = up ? 1 : 2;
                m_steps = (m_steps + 1) % 256;
                if (m_seen && m_dirup != up) m_dirchg = 1;
                m_dirup = up;
                m_seen = 1;
                if (up && v == 0) m_wrap = 1;
            end else begin
                m_last = 3;
                if (m_jumps < 255) m_jumps++;
                m_jst = 1;
            end
        end
        m_prev = v;
        m_track = 1;
    endtask

    function automatic logic [7:0] mdl_status();
        return {1'b0, m_wrap, m_jst, m_dirchg, m_dirup, m_track, 2'(m_last)};
    endfunction

    task automatic view(input logic [1:0] sel, output logic [7:0] v);
        ui_in = {4'h0, sel, 2'b00};
        #1;
        v = uo_out;
        ui_in = '0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] v;
        view(2'b00, v); chk({tag, ".steps"}, v, 8'(m_steps));
        view(2'b01, v); chk({tag, ".jumps"}, v, 8'(m_jumps));
        view(2'b10, v); chk({tag, ".prev"}, v, 8'(m_prev));
        view(2'b11, v); chk({tag, ".status"}, v, mdl_status());
        chk({tag, ".uio_oe"}, uio_oe | uio_out, 8'h00);
    endtask

    task automatic do_sample(input int v);
        uio_in = 8'(v);
        ui_in = '0;
        repeat (SETTLE) tick();
        ui_in = 8'h01;
        tick();
        ui_in = '0;
        mdl_sample(v);
    endtask

    task automatic do_clear(input bit with_sample);
        ui_in = with_sample ? 8'h03 : 8'h02;
        tick();
        ui_in = '0;
        mdl_clear();
    endtask

    initial begin
        logic [7:0] v;
        int op, nv;
        mdl_clear();
        #12;
        view(2'b11, v); chk("reset_status", v, 8'h00);
        view(2'b00, v); chk("reset_uo_out", v, 8'h00);
        rst_n = 1'b1;
        tick();

        do_sample(8'h10);
        view(2'b11, v); chk("first_status", v, 8'h04);
        check_all("first");

        do_sample(8'h11); do_sample(8'h12); do_sample(8'h11);
        view(2'b00, v); chk("ud_steps", v, 8'd3);
        view(2'b11, v); chk("ud_status", v, 8'h16);
        check_all("updown");

        do_clear(0);
        do_sample(8'hFE); do_sample(8'hFF); do_sample(8'h00);
        view(2'b11, v); chk("wrap_status", v, 8'h4D);
        do_sample(8'hFF);
        view(2'b11, v); chk("unwrap_status", v, 8'h56);
        check_all("wrap");

        do_clear(0);
        do_sample(8'h20);
        for (int i = 0; i < 300; i++) do_sample((i % 2 == 0) ? 8'h40 : 8'h20);
        view(2'b01, v); chk("jump_sat", v, 8'd255);
        check_all("jumps");

        ui_in = 8'h04;
        rst_n = 1'b0;
        #2;
        chk("async_reset", uo_out, 8'h00);
        ui_in = '0;
        mdl_clear();
        tick();
        rst_n = 1'b1;
        tick();
        check_all("after_reset");

        do_sample(8'h33); do_sample(8'h34);
        do_clear(1);
        check_all("clear_beats_sample");
        do_sample(8'h50); do_sample(8'h51);
        ena = 1'b0;
        ui_in = 8'h03;
        tick();
        ena = 1'b1;
        ui_in = '0;
        check_all("ena_blocks_clear");

        do_clear(0);
        uio_in = 8'h05;
        repeat (SETTLE) tick();
        ui_in = 8'h01;
        repeat (3) tick();
        uio_in = 8'h85;
        tick();
        uio_in = 8'h05;
        repeat (SETTLE + 2) tick();
        ui_in = '0;
        view(2'b01, v);
`ifdef MON_GLITCH_FILTER_EN
        chk("glitch_jumps", v, 8'd0);
`else
        chk("glitch_jumps", v, 8'd2);
`endif
        view(2'b00, v); chk("glitch_steps", v, 8'd0);
        do_clear(0);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0: nv = (m_prev + 1) % 256;
                1: nv = (m_prev + 255) % 256;
                2: nv = m_prev;
                3: nv = ($urandom_range(0, 1) == 1) ? 255 : 0;
                default: nv = $urandom_range(0, 255);
            endcase
            if (op <= 6) do_sample(nv);
            else if (op == 7) do_clear(0);
            else if (op == 8) begin
                uio_in = 8'(nv);
                ena = 1'b0;
                ui_in = 8'($urandom_range(1, 3));
                repeat (SETTLE + 1) tick();
                ena = 1'b1;
                ui_in = '0;
            end else do_clear(1);
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
